// File: rtl/pll_clk_enable_gen.sv
// Multi-channel fractional clock-enable generator on the PLL output clock.
// Each channel's phase-accumulator carry becomes a 1-cycle ce strobe, released only while PLL lock is qualified.
module pll_clk_enable_gen #(
    parameter int                        NUM_CH        = 4,
    parameter int                        ACC_W         = 32,
    parameter int                        STABLE_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0]   INC_DEFAULT   = '0
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked,
    input  logic                sync_req,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   ce,
    output logic                ready,
    output logic [7:0]          unlock_cnt
);

    localparam int              SC_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0] STAB_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [4:0]      NUM_CH_L  = 5'(NUM_CH);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILISE,
        RUN
    } state_t;

    state_t            state, state_next;
    logic [SC_W-1:0]   stab_cnt, stab_next;
    logic              lk_meta, lk_s;

    logic [ACC_W-1:0]  acc        [NUM_CH];
    logic [ACC_W-1:0]  pending    [NUM_CH];
    logic [ACC_W-1:0]  inc_active [NUM_CH];
    logic [ACC_W:0]    sum        [NUM_CH];
    logic [ACC_W-1:0]  pend_next  [NUM_CH];
    logic [NUM_CH-1:0] promote;

    logic cfg_acc, cfg_bad, run_adv, run_sync;

    // locked is asynchronous to refclk; two flops before anything decodes it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking here so lk_s takes the old lk_meta, giving a true two-stage chain.
            lk_meta <= locked;
            lk_s    <= lk_meta;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
        end else begin
            state    <= state_next;
            stab_cnt <= stab_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next = state;
        stab_next  = '0;
        case (state)
            WAIT_LOCK: if (lk_s) state_next = STABILISE;
            STABILISE: begin
                if (!lk_s)                    state_next = WAIT_LOCK;
                else if (stab_cnt == STAB_LAST) state_next = RUN;
                else                          stab_next  = stab_cnt + 1'b1;
            end
            RUN:       if (!lk_s) state_next = WAIT_LOCK;
            default:   state_next = WAIT_LOCK;
        endcase
    end

    assign ready    = (state == RUN);
    assign cfg_acc  = cfg_valid & cfg_ready;
    assign cfg_bad  = ({1'b0, cfg_ch} >= NUM_CH_L);
    // Lock loss outranks sync_req: neither advance nor realign once lk_s has dropped.
    assign run_adv  = (state == RUN) & lk_s & ~sync_req;
    assign run_sync = (state == RUN) & lk_s & sync_req;

    // A write landing on the carry cycle is promoted straight away through pend_next.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i]       = {1'b0, acc[i]} + {1'b0, inc_active[i]};
            pend_next[i] = (cfg_acc && cfg_ch == 4'(i)) ? cfg_inc : pending[i];
            promote[i]   = (state != RUN) | run_sync | (run_adv & sum[i][ACC_W]);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cfg_ready  <= 1'b0;
            cfg_err    <= 1'b0;
            unlock_cnt <= '0;
            ce         <= '0;
            // NOTE: these arrays are a handful of registers, not RAM, so they take a reset value.
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]        <= '0;
                pending[i]    <= INC_DEFAULT[i*ACC_W +: ACC_W];
                inc_active[i] <= INC_DEFAULT[i*ACC_W +: ACC_W];
            end
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_acc & cfg_bad;
            if (state == RUN && !lk_s && unlock_cnt != 8'hFF)
                unlock_cnt <= unlock_cnt + 8'd1;
            for (int i = 0; i < NUM_CH; i++) begin
                pending[i] <= pend_next[i];
                if (promote[i])
                    inc_active[i] <= pend_next[i];
                if (run_adv) begin
                    acc[i] <= sum[i][ACC_W-1:0];
                    ce[i]  <= sum[i][ACC_W];
                end else begin
                    acc[i] <= '0;
                    ce[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_clk_enable_gen.sv
// Directed bench for pll_clk_enable_gen with ACC_W=8, STABLE_CYCLES=16, NUM_CH=4.
// Expected values are hand-derived edge counts and closed-form carry patterns.
module tb_pll_clk_enable_gen;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 8;
    localparam int STABLE = 16;

    logic              refclk = 1'b0;
    logic              rst, locked, sync_req, cfg_valid;
    logic              cfg_ready, cfg_err, ready;
    logic [3:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [NUM_CH-1:0] ce;
    logic [7:0]        unlock_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pll_clk_enable_gen #(
        .NUM_CH        (NUM_CH),
        .ACC_W         (ACC_W),
        .STABLE_CYCLES (STABLE),
        .INC_DEFAULT   ('0)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .sync_req   (sync_req),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_err    (cfg_err),
        .ce         (ce),
        .ready      (ready),
        .unlock_cnt (unlock_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [ACC_W-1:0] inc);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int cnt0, cnt1, cnt1_first8;
        logic e0, e1;
        logic [NUM_CH-1:0] ce_or;

        rst = 1'b1; locked = 1'b0; sync_req = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
        repeat (3) step();
        check("rst_ready",     32'(ready),      32'd0);
        check("rst_ce",        32'(ce),         32'd0);
        check("rst_cfg_err",   32'(cfg_err),    32'd0);
        check("rst_unlock",    32'(unlock_cnt), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready),  32'd0);

        // Lock qualification: edges 0..17 not ready, RUN after edge 18.
        rst = 1'b0; locked = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step();
            if (k == 2)  check("stab_ready_early", 32'(ready), 32'd0);
            if (k == 17) check("ready_edge17", 32'(ready), 32'd0);
        end
        step();
        check("ready_edge18", 32'(ready),      32'd1);
        check("unlock_run0",  32'(unlock_cnt), 32'd0);
        check("cfg_ready_up", 32'(cfg_ready),  32'd1);

        // inc=0 everywhere: no strobes at all.
        ce_or = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            ce_or |= ce;
        end
        check("inc0_no_ce", 32'(ce_or), 32'd0);

        // Rate check: ch0=64, ch1=96, aligned by sync_req which also promotes them.
        cfg_write(4'd0, 8'd64);
        cfg_write(4'd1, 8'd96);
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        check("sync_ce_zero", 32'(ce), 32'd0);
        cnt0 = 0; cnt1 = 0; cnt1_first8 = 0;
        for (int n = 1; n <= 256; n++) begin
            step();
            e0 = (n % 4 == 0);
            e1 = (((n * 96) >> 8) != (((n - 1) * 96) >> 8));
            check("rate_ce", 32'(ce), 32'({2'b00, e1, e0}));
            cnt0 += int'(ce[0]);
            cnt1 += int'(ce[1]);
            if (n == 8) cnt1_first8 = cnt1;
        end
        check("rate_ch0_total",  32'(cnt0),        32'd64);
        check("rate_ch1_total",  32'(cnt1),        32'd96);
        check("rate_ch1_first8", 32'(cnt1_first8), 32'd3);

        // Glitch-free change: acc0 is 0 here; after one more edge it is 64, then write 128.
        step();
        cfg_write(4'd0, 8'd128);
        check("good_write_no_err", 32'(cfg_err), 32'd0);
        for (int m = 1; m <= 16; m++) begin
            if (m == 9) begin
                cfg_valid = 1'b1; cfg_ch = 4'd7; cfg_inc = 8'd200;
            end else begin
                cfg_valid = 1'b0;
            end
            step();
            check("glitchfree_ce0", 32'(ce[0]), 32'(m % 2 == 0));
            if (m == 9)  check("bad_ch_err_pulse", 32'(cfg_err), 32'd1);
            if (m == 10) check("bad_ch_err_clear", 32'(cfg_err), 32'd0);
        end

        // sync_req with ch0=64, ch1=32: ce0 at +4 and +8, ce1 at +8.
        cfg_write(4'd0, 8'd64);
        cfg_write(4'd1, 8'd32);
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        check("sync2_ce_zero", 32'(ce),    32'd0);
        check("sync2_ready",   32'(ready), 32'd1);
        for (int m = 1; m <= 8; m++) begin
            step();
            check("sync2_ce", 32'(ce), 32'({2'b00, m == 8, m % 4 == 0}));
        end

        // Lock loss in RUN: ready still up after 2 edges, down after 3.
        locked = 1'b0;
        step(); step();
        check("loss_ready_2", 32'(ready), 32'd1);
        step();
        check("loss_ready_3",  32'(ready),      32'd0);
        check("loss_ce_3",     32'(ce),         32'd0);
        check("loss_unlock_1", 32'(unlock_cnt), 32'd1);
        ce_or = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            ce_or |= ce;
        end
        check("wait_lock_no_ce", 32'(ce_or), 32'd0);

        // Lock glitch at stab_cnt=10 (after edge 12): re-entry to STABILISE at edge 16, RUN at edge 32.
        locked = 1'b1;
        repeat (13) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        for (int k = 14; k <= 31; k++) begin
            step();
            if (k == 18) check("glitch_ready_18", 32'(ready), 32'd0);
            if (k == 31) check("glitch_ready_31", 32'(ready), 32'd0);
        end
        step();
        check("glitch_ready_32", 32'(ready),      32'd1);
        check("glitch_unlock",   32'(unlock_cnt), 32'd1);

        // 300 more losses: counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            repeat (3) step();
            if (i == 0 || i == 252 || i == 253 || i == 299)
                check("unlock_sat", 32'(unlock_cnt), (i + 2 > 255) ? 32'd255 : 32'(i + 2));
            locked = 1'b1;
            repeat (19) step();
        end
        check("unlock_final_run", 32'(ready), 32'd1);

        // Reset mid-operation discards the pending write to ch2 and all active increments.
        cfg_write(4'd2, 8'd255);
        rst = 1'b1;
        step();
        check("rst2_ready",     32'(ready),      32'd0);
        check("rst2_unlock",    32'(unlock_cnt), 32'd0);
        check("rst2_ce",        32'(ce),         32'd0);
        check("rst2_cfg_ready", 32'(cfg_ready),  32'd0);
        rst = 1'b0;
        repeat (18) step();
        check("rst2_ready_17", 32'(ready), 32'd0);
        step();
        check("rst2_ready_18", 32'(ready), 32'd1);
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        ce_or = '0;
        for (int k = 0; k < 16; k++) begin
            step();
            ce_or |= ce;
        end
        check("rst2_pending_gone", 32'(ce_or), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
